// File: rtl/prog_clock_divider_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_W_DEFAULT : default divisor register width
//   MIN_DIV       : smallest divisor a channel accepts
//   ch_idx_w()    : width of a channel index for a given channel count
package prog_clock_divider_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int MIN_DIV       = 2;

    // A single channel still needs a 1-bit index port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: modulo-D counter, active/shadow divisor registers,
// pending flag and the registered divided-clock / tick outputs.
//   clk, rst  : system clock, asynchronous active-low reset
//   en        : channel run enable (level)
//   sync      : restart counter and apply pending divisor now
//   wr        : legal, already-decoded divisor write for this channel
//   wr_div    : divisor carried by the write
//   clk_div   : registered divided clock (high for floor(D/2) cycles)
//   tick      : one-cycle pulse at the start of each output period
//   pending   : a shadow divisor waits for the next period boundary
module clk_div_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = MIN_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_div,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        clk_div_d = 1'b0;
        tick_d    = 1'b0;
        wrap      = (cnt_q == div_q - DIV_W'(1));

        if (!en) begin
            // Idle channel: no period in flight, so a write can land directly.
            cnt_d = '0;
            if (wr) begin
                div_d    = wr_div;
                shadow_d = wr_div;
                pend_d   = 1'b0;
            end
        end else begin
            clk_div_d = (cnt_q < (div_q >> 1));
            tick_d    = (cnt_q == '0);

            // sync and the natural wrap both start a fresh period; the
            // shadow is only swapped in at that point so no short pulse
            // can appear.
            if (sync || wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = shadow_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            // A write in the same cycle as an apply becomes the next shadow;
            // the apply above has already consumed the old one.
            if (wr) begin
                shadow_d = wr_div;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            div_q     <= DIV_W'(DEFAULT_DIV);
            shadow_q  <= DIV_W'(DEFAULT_DIV);
            pend_q    <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
//   clk, rst   : system clock, asynchronous active-low reset
//   en         : per-channel run enable
//   sync       : phase-align strobe for all enabled channels
//   cfg_valid  : divisor write request
//   cfg_ch     : channel targeted by the write
//   cfg_div    : new divisor (values below MIN_DIV are dropped)
//   cfg_ready  : high once out of reset; writes are accepted while high
//   clk_div    : registered divided clock per channel
//   tick       : one-cycle period-start pulse per channel
//   pending    : per-channel shadow-divisor-waiting flag
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic              rdy_q, rdy_d;
    logic              wr_ok;
    logic [NUM_CH-1:0] wr_ch;

    always_comb begin
        rdy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    assign cfg_ready = rdy_q;

    // Illegal divisors are filtered once here so channels never see them.
    assign wr_ok = cfg_valid && rdy_q && (cfg_div >= DIV_W'(MIN_DIV));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_ch[i] = wr_ok && (cfg_ch == CH_W'(i));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_ch[i]),
            .wr_div  (cfg_div),
            .clk_div (clk_div[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_valid;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    prog_clock_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_div   (clk_div),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a period of length per_len that is
    // age cycles old; outputs describe the age seen on the previous cycle.
    int per_len [NUM_CH];
    int nxt_len [NUM_CH];
    bit has_nxt [NUM_CH];
    int age     [NUM_CH];
    bit exp_hi  [NUM_CH];
    bit exp_tk  [NUM_CH];
    bit exp_rdy;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            per_len[c] = DEFAULT_DIV;
            nxt_len[c] = DEFAULT_DIV;
            has_nxt[c] = 0;
            age[c]     = 0;
            exp_hi[c]  = 0;
            exp_tk[c]  = 0;
        end
        exp_rdy = 0;
    endtask

    task automatic model_edge();
        bit accept;
        bit new_period;
        if (!rst) begin
            model_reset();
            return;
        end
        accept = cfg_valid && exp_rdy && (int'(cfg_div) >= 2);
        for (int c = 0; c < NUM_CH; c++) begin
            bit mine;
            mine = accept && (int'(cfg_ch) == c);
            if (!en[c]) begin
                exp_hi[c] = 0;
                exp_tk[c] = 0;
                age[c]    = 0;
                if (mine) begin
                    per_len[c] = int'(cfg_div);
                    nxt_len[c] = int'(cfg_div);
                    has_nxt[c] = 0;
                end
            end else begin
                exp_hi[c]  = (age[c] < per_len[c] / 2);
                exp_tk[c]  = (age[c] == 0);
                new_period = sync || (age[c] + 1 == per_len[c]);
                if (new_period) begin
                    age[c] = 0;
                    if (has_nxt[c]) begin
                        per_len[c] = nxt_len[c];
                        has_nxt[c] = 0;
                    end
                end else begin
                    age[c] = age[c] + 1;
                end
                if (mine) begin
                    nxt_len[c] = int'(cfg_div);
                    has_nxt[c] = 1;
                end
            end
        end
        exp_rdy = 1;
    endtask

    task automatic check(input string tag, input logic [NUM_CH-1:0] obs,
                         input logic [NUM_CH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] e_hi, e_tk, e_pd;
        for (int c = 0; c < NUM_CH; c++) begin
            e_hi[c] = exp_hi[c];
            e_tk[c] = exp_tk[c];
            e_pd[c] = has_nxt[c];
        end
        check("clk_div", clk_div, e_hi);
        check("tick", tick, e_tk);
        check("pending", pending, e_pd);
        check("cfg_ready", {3'b000, cfg_ready}, {3'b000, exp_rdy});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DIV_W'(div);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_age(input int ch, input int target);
        for (int k = 0; k < 64 && age[ch] != target; k++) step();
        check("wait_age", 4'(age[ch] == target), 4'd1);
    endtask

    int cnt_a, cnt_b;

    initial begin
        rst = 1'b0; en = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        #1;
        compare_all();
        step(); step();
        rst = 1'b1;
        step(); step();

        // D=2 on channel 0 only
        en = 4'b0001;
        repeat (8) step();

        // odd divisor 5 on channel 1, written while idle
        write(1, 5);
        en = 4'b0011;
        cnt_a = 0; cnt_b = 0;
        repeat (10) begin
            step();
            cnt_a += int'(clk_div[1]);
            cnt_b += int'(tick[1]);
        end
        check("d5_high_cycles", 4'(cnt_a), 4'd4);
        check("d5_ticks", 4'(cnt_b), 4'd2);

        // channel 0: D=8, change to 3 at count 2
        en = 4'b0010;
        step();
        write(0, 8);
        en = 4'b0011;
        wait_age(0, 2);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        cnt_a = int'(pending[0]);
        repeat (8) begin
            step();
            cnt_a += int'(pending[0]);
        end
        check("pending_len", 4'(cnt_a), 4'd5);
        repeat (6) step();

        // channel 2: back-to-back 6 then 4 before the boundary
        write(2, 8);
        en = 4'b0111;
        step(); step();
        write(2, 6);
        write(2, 4);
        repeat (6) step();
        cnt_b = 0;
        repeat (8) begin
            step();
            cnt_b += int'(tick[2]);
        end
        check("d4_ticks", 4'(cnt_b), 4'd2);

        // D=4 and D=6 out of phase, then sync with a pending divisor
        en = 4'b0100;
        step();
        write(0, 4);
        write(1, 6);
        en = 4'b0101;
        step();
        en = 4'b0111;
        repeat (5) step();
        write(0, 3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        check("sync_ticks", {2'b00, tick[1:0]}, 4'b0011);
        check("sync_applied", {3'b000, pending[0]}, 4'b0000);
        repeat (10) step();

        // reset mid-operation with channel 3 at count 5 and pending
        en = 4'b0111;
        step();
        write(3, 8);
        en = 4'b1111;
        wait_age(3, 4);
        write(3, 5);
        check("pre_rst_pending", {3'b000, pending[3]}, 4'b0001);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(); step();
        rst = 1'b1;
        step();
        write(0, 1);
        check("illegal_wr", pending, 4'b0000);
        cnt_b = 0;
        repeat (6) begin
            step();
            cnt_b += int'(tick[0]);
        end
        check("default_ticks", 4'(cnt_b), 4'd3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom);
            cfg_div   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9))
                                                    : 8'($urandom_range(0, 40));
            sync      = ($urandom_range(0, 31) == 0);
            step();
        end
        cfg_valid = 1'b0;
        sync = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel, runtime-programmable clock divider. It generalises the fixed power-of-two divider into NUM_CH independent channels. Each channel has an arbitrary integer divisor, a per-channel enable, glitch-free divisor updates at period boundaries, and a phase-align strobe. Outputs are registered divided clocks plus one-cycle tick pulses, used as clock-enables by downstream logic in the same `clk` domain.

## Interface
- NUM_CH, 4, number of independent divider channels
- DIV_W, 8, divisor width; legal divisors 2..2^DIV_W-1
- DEFAULT_DIV, 2, divisor loaded into every channel at reset
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- en  input  NUM_CH  per-channel run enable, level-sensitive
- sync  input  1  phase-align strobe, restarts all enabled channels together
- cfg_valid  input  1  divisor write request
- cfg_ch  input  $clog2(NUM_CH)  target channel of write
- cfg_div  input  DIV_W  new divisor
- cfg_ready  output  1  always 1 after reset; write accepted when cfg_valid
- clk_div  output  NUM_CH  registered divided clock per channel
- tick  output  NUM_CH  one-cycle pulse at start of each output period
- pending  output  NUM_CH  shadow divisor waiting for period boundary

## Operation
- Per channel: active divisor D, shadow divisor S with pending flag, counter cnt (DIV_W bits).
- Reset (rst=0): D=DEFAULT_DIV, pending=0, cnt=0, clk_div=0, tick=0. cfg_ready=0 during reset.
- Counting (en=1): cnt <= (cnt==D-1) ? 0 : cnt+1.
- Registered outputs: clk_div <= (cnt < D>>1); tick <= (cnt==0). Outputs lag cnt by one cycle. High time is floor(D/2) cycles and low time is ceil(D/2) cycles. Even D gives 50% duty.
- en=0: cnt forced to 0; clk_div and tick forced low on the next edge. Re-enable restarts at cnt=0, so tick fires one cycle after en rises.
- Config write (cfg_valid=1): S <= cfg_div, pending <= 1.
  - If the channel has en=0, the write applies directly: D <= cfg_div, pending stays 0.
  - A second write while pending overwrites S; the last write wins.
- Boundary apply: when cnt==D-1 and pending=1, D <= S, pending <= 0, cnt <= 0. The new period starts with no truncated pulse.
- Illegal divisor (cfg_div<2): write ignored, no state change.
- sync=1: every enabled channel sets cnt <= 0 and applies any pending S immediately. sync has priority over the boundary apply. A cfg write to the same channel in the same cycle lands in S and stays pending.
- Write and boundary in the same cycle on the same channel: the boundary applies the old S, and the new write becomes S with pending=1.

## Timing
- Latency from en rise to first tick: 1 cycle. First clk_div high: 1 cycle.
- Divisor change: takes effect at the first wrap after the write, never mid-period. Worst case is D_old cycles.
- Reset assertion mid-operation clears all state asynchronously. Outputs go low immediately, not at the next edge.
- tick period is exactly D cycles in steady state. Counter wrap is modulo D, never 2^DIV_W.

## Structure
- Shared package holds DIV_W_DEFAULT, MIN_DIV=2, and the channel-index width function.
- Sub-module `clk_div_channel` holds one channel: counter, D/S registers, pending flag, output registers. The top level generates NUM_CH instances and decodes cfg_ch into per-channel write strobes.
- Top-level glue is the write decode plus sync fan-out.

## Test plan
- Reset then en=4'b0001 with D=2: clk_div[0] toggles every cycle starting 1 cycle after en; tick[0] pulses every 2 cycles; other channels stay 0.
- Odd divisor: write cfg_div=5 to ch1 while disabled, then enable. Expected: clk_div[1] high 2 cycles and low 3; tick period 5.
- Write cfg_div=3 to ch0 mid-period of D=8 at cnt=2. Expected: pending[0]=1 for 5 cycles; the next period has tick spacing 3; no clk_div pulse shorter than 1 high cycle.
- Back-to-back writes 6 then 4 to ch2 before the boundary. Expected: only D=4 applied; pending clears at the wrap.
- Channels at D=4 and D=6 running out of phase, then sync=1. Expected: both ticks fire on the same cycle after sync; a pending divisor is applied at that instant.
- rst pulled low with cnt=5 and pending=1. Expected: all outputs 0 immediately; after release D=DEFAULT_DIV and pending=0. cfg_div=1 write: ignored.
